qspi_flash_responder: RTL and testbench

Synthesizable QSPI flash responder that emulates an external quad-I/O NOR flash for FPGA prototyping and for self-contained chip-level simulation. It connects to the SoC's flash port (FSCK, FCEN, FDO, FDOEN, FDI) from the flash side and answers quad I/O fast read (0xEB) transactions. Read data comes from a backing synchronous 32-bit memory with 1-cycle read latency and the same timing as the chip SRAM macro. The flash pins are oversampled in the clk domain, so no FSCK-clocked logic is needed.

---
 rtl/qspi_flash_pkg.sv | 22 ++
 rtl/qspi_flash_responder_if.sv | 15 +
 rtl/qspi_pin_sync.sv | 45 ++++
 rtl/qspi_flash_responder.sv | 150 +++++++++++++++
 tb/tb_qspi_flash_responder.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qspi_flash_pkg.sv
// Shared definitions for the QSPI flash responder: FSM encoding, opcode,
// XIP mode-bit pattern and per-phase nibble counts.
package qspi_flash_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    MODE,
    DUMMY,
    DATA,
    IGNORE
  } state_t;

  localparam logic [7:0] CMD_QREAD_EB  = 8'hEB;
  localparam logic [1:0] XIP_MODE_BITS = 2'b10;

  localparam int CMD_BITS     = 8;
  localparam int ADDR_NIBBLES = 6;
  localparam int MODE_NIBBLES = 2;

endpackage

// File: rtl/qspi_flash_responder_if.sv
// Flash-port pin bundle between the SoC flash controller (master) and the
// responder (slave).
interface qspi_flash_responder_if;

  logic       FSCK;
  logic       FCEN;
  logic [3:0] FDO;
  logic       FDOEN;
  logic [3:0] FDI;
  logic       FDI_OE;

  modport master (output FSCK, FCEN, FDO, FDOEN, input FDI, FDI_OE);
  modport slave  (input FSCK, FCEN, FDO, FDOEN, output FDI, FDI_OE);

endinterface

// File: rtl/qspi_pin_sync.sv
// Two-flop synchronizers for the flash pins plus FSCK/FCEN edge pulses,
// so the responder runs entirely in the clk domain.
module qspi_pin_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       FSCK,
  input  logic       FCEN,
  input  logic [3:0] FDO,
  output logic [3:0] fdo_s,
  output logic       fcen_s,
  output logic       rise,
  output logic       fall,
  output logic       cs_start,
  output logic       cs_end
);

  logic [2:0] fsck_r;
  logic [2:0] fcen_r;
  logic [3:0] fdo_r1;
  logic [3:0] fdo_r2;

  // FCEN resets low so a transfer interrupted by rst is not re-entered until
  // the master raises and lowers FCEN again.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsck_r <= '0;
      fcen_r <= '0;
      fdo_r1 <= '0;
      fdo_r2 <= '0;
    end else begin
      fsck_r <= {fsck_r[1:0], FSCK};
      fcen_r <= {fcen_r[1:0], FCEN};
      fdo_r1 <= FDO;
      fdo_r2 <= fdo_r1;
    end
  end

  assign fdo_s    = fdo_r2;
  assign fcen_s   = fcen_r[1];
  assign rise     = fsck_r[1] & ~fsck_r[2];
  assign fall     = ~fsck_r[1] & fsck_r[2];
  assign cs_start = ~fcen_r[1] & fcen_r[2];
  assign cs_end   = fcen_r[1] & ~fcen_r[2];

endmodule

// File: rtl/qspi_flash_responder.sv
// Quad-I/O fast-read (0xEB) flash emulator backed by a 1-cycle-latency memory.
// Define QSPI_FLASH_RESPONDER_XIP_EN to honour the continuous-read mode byte.
module qspi_flash_responder
  import qspi_flash_pkg::*;
#(
  parameter int         FLASH_AW     = 16,
  parameter int         DUMMY_CYCLES = 4,
  parameter logic [7:0] CMD_QREAD    = CMD_QREAD_EB
) (
  input  logic                  clk,
  input  logic                  rst,
  qspi_flash_responder_if.slave flash,
  output logic [FLASH_AW-3:0]   MEM_ADDR,
  output logic                  MEM_RE,
  input  logic [31:0]           MEM_RDATA,
  output logic                  BUSY,
  output logic                  PROTO_ERR
);

  localparam logic [7:0] CMD_LAST   = 8'(CMD_BITS - 1);
  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_NIBBLES - 1);
  localparam logic [7:0] MODE_LAST  = 8'(MODE_NIBBLES - 1);
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CYCLES - 1);

  logic [3:0]          fdo_s;
  logic                fcen_s, rise, fall, cs_start, cs_end;
  state_t              state_q, state_d;
  logic [7:0]          cnt_q;
  logic [FLASH_AW-1:0] sr_q, shift_in, addr_q, addr_inc;
  logic [7:0]          byte_q, opcode;
  logic [3:0]          lo_q, fdi_q;
  logic                hi_q, rd_pend_q, xip_q, fdi_oe_q;

  qspi_pin_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .FSCK     (flash.FSCK),
    .FCEN     (flash.FCEN),
    .FDO      (flash.FDO),
    .fdo_s    (fdo_s),
    .fcen_s   (fcen_s),
    .rise     (rise),
    .fall     (fall),
    .cs_start (cs_start),
    .cs_end   (cs_end)
  );

  // Address bits above FLASH_AW simply fall off the top of the shifter.
  assign shift_in = FLASH_AW'({sr_q, fdo_s});
  assign opcode   = {sr_q[6:0], fdo_s[0]};
  assign addr_inc = addr_q + FLASH_AW'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cs_start) state_d = xip_q ? ADDR : CMD;
      CMD:     if (rise && cnt_q == CMD_LAST) state_d = (opcode == CMD_QREAD) ? ADDR : IGNORE;
      ADDR:    if (rise && cnt_q == ADDR_LAST) state_d = MODE;
      MODE:    if (rise && cnt_q == MODE_LAST) state_d = DUMMY;
      DUMMY:   if (rise && cnt_q == DUMMY_LAST) state_d = DATA;
      default: ;
    endcase
    if (fcen_s) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sr_q      <= '0;
      addr_q    <= '0;
      byte_q    <= '0;
      lo_q      <= '0;
      hi_q      <= 1'b1;
      rd_pend_q <= 1'b0;
      xip_q     <= 1'b0;
      fdi_q     <= '0;
      fdi_oe_q  <= 1'b0;
      MEM_ADDR  <= '0;
      MEM_RE    <= 1'b0;
      PROTO_ERR <= 1'b0;
    end else begin
      state_q   <= state_d;
      MEM_RE    <= 1'b0;
      rd_pend_q <= MEM_RE;
      if (rd_pend_q) byte_q <= MEM_RDATA[{addr_q[1:0], 3'b000} +: 8];
      if (flash.FDOEN && fdi_oe_q) PROTO_ERR <= 1'b1;
      if (fcen_s) begin
        cnt_q    <= '0;
        hi_q     <= 1'b1;
        fdi_q    <= '0;
        fdi_oe_q <= 1'b0;
        if (cs_end && ((state_q == CMD && cnt_q != 8'd0) || (state_q == ADDR && cnt_q[0])))
          PROTO_ERR <= 1'b1;
      end else begin
        case (state_q)
          CMD: if (rise) begin
            sr_q  <= {sr_q[FLASH_AW-2:0], fdo_s[0]};
            cnt_q <= (cnt_q == CMD_LAST) ? 8'd0 : cnt_q + 8'd1;
          end
          ADDR: if (rise) begin
            sr_q <= shift_in;
            if (cnt_q == ADDR_LAST) begin
              cnt_q    <= '0;
              addr_q   <= shift_in;
              MEM_ADDR <= shift_in[FLASH_AW-1:2];
              MEM_RE   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          MODE: if (rise) begin
            sr_q <= shift_in;
            if (cnt_q == MODE_LAST) begin
              cnt_q <= '0;
`ifdef QSPI_FLASH_RESPONDER_XIP_EN
              xip_q <= (shift_in[5:4] == XIP_MODE_BITS);
`endif
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          DUMMY: if (rise) cnt_q <= (cnt_q == DUMMY_LAST) ? 8'd0 : cnt_q + 8'd1;
          // The low nibble is parked in lo_q because byte_q is refilled
          // from the next address before the low nibble goes out.
          DATA: if (fall) begin
            fdi_oe_q <= 1'b1;
            if (hi_q) begin
              fdi_q    <= byte_q[7:4];
              lo_q     <= byte_q[3:0];
              addr_q   <= addr_inc;
              MEM_ADDR <= addr_inc[FLASH_AW-1:2];
              MEM_RE   <= 1'b1;
              hi_q     <= 1'b0;
            end else begin
              fdi_q <= lo_q;
              hi_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign flash.FDI    = fdi_q;
  assign flash.FDI_OE = fdi_oe_q;
  assign BUSY         = (state_q != IDLE);

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Bench for qspi_flash_responder: a QSPI master drives reads, a scoreboard
// queue holds the nibbles the flash contents say should come back.
module tb_qspi_flash_responder;

  localparam int AW    = 16;
  localparam int DUMMY = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-3:0] mem_addr;
  logic          mem_re;
  logic [31:0]   mem_rdata;
  logic          busy;
  logic          proto_err;

  int total = 0;
  int bad   = 0;
  int re_count = 0;
  logic [3:0]    exp_q[$];
  logic [AW-3:0] re_log[$];
  logic [31:0]   mem [0:(1<<(AW-2))-1];

  qspi_flash_responder_if fif ();

  qspi_flash_responder #(
    .FLASH_AW     (AW),
    .DUMMY_CYCLES (DUMMY),
    .CMD_QREAD    (8'hEB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flash     (fif),
    .MEM_ADDR  (mem_addr),
    .MEM_RE    (mem_re),
    .MEM_RDATA (mem_rdata),
    .BUSY      (busy),
    .PROTO_ERR (proto_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

  always @(negedge clk) begin
    if (mem_re) begin
      re_count++;
      re_log.push_back(mem_addr);
    end
  end

  function automatic logic [7:0] byte_of(input logic [AW-1:0] a);
    logic [31:0] w;
    w = mem[a[AW-1:2]];
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  task automatic sck_cycle(input logic [3:0] d);
    fif.FDO = d;
    #50 fif.FSCK = 1'b1;
    #50 fif.FSCK = 1'b0;
  endtask

  // One framed transaction; expected nibbles go on the scoreboard up front
  // and are popped at each data-phase rising edge of FSCK.
  task automatic qspi_txn(input logic send_cmd, input logic [7:0] op, input logic [23:0] addr,
                          input logic [7:0] mode, input int n_data, input logic expect_data,
                          input logic fdoen_data);
    logic [7:0] b;
    logic [3:0] nib;
    if (expect_data)
      for (int k = 0; k < n_data; k++) begin
        b = byte_of(AW'(addr) + AW'(k / 2));
        exp_q.push_back((k % 2 == 0) ? b[7:4] : b[3:0]);
      end
    fif.FCEN  = 1'b0;
    fif.FDOEN = 1'b1;
    #50;
    if (send_cmd) for (int i = 7; i >= 0; i--) sck_cycle({3'b000, op[i]});
    for (int i = 5; i >= 0; i--) sck_cycle(addr[4*i +: 4]);
    sck_cycle(mode[7:4]);
    sck_cycle(mode[3:0]);
    fif.FDOEN = 1'b0;
    for (int i = 0; i < DUMMY; i++) sck_cycle(4'h0);
    total++;
    if (fif.FDI_OE !== 1'b0) begin
      bad++;
      $display("FAIL oe_before_data: got %b want 0", fif.FDI_OE);
    end
    fif.FDOEN = fdoen_data;
    for (int k = 0; k < n_data; k++) begin
      #50 fif.FSCK = 1'b1;
      if (expect_data) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL scoreboard_empty: got nibble %h want none", fif.FDI);
        end else begin
          nib = exp_q.pop_front();
          if (fif.FDI !== nib) begin
            bad++;
            $display("FAIL data_nibble addr=%h k=%0d: got %h want %h", addr, k, fif.FDI, nib);
          end
        end
        total++;
        if (fif.FDI_OE !== 1'b1) begin
          bad++;
          $display("FAIL oe_in_data k=%0d: got %b want 1", k, fif.FDI_OE);
        end
      end else begin
        total++;
        if (fif.FDI_OE !== 1'b0) begin
          bad++;
          $display("FAIL oe_ignored k=%0d: got %b want 0", k, fif.FDI_OE);
        end
      end
      #50 fif.FSCK = 1'b0;
    end
    fif.FDOEN = 1'b0;
    #20 fif.FCEN = 1'b1;
    #40;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL busy_after_fcen: got %b want 0", busy);
    end
    total++;
    if (fif.FDI_OE !== 1'b0) begin
      bad++;
      $display("FAIL oe_after_fcen: got %b want 0", fif.FDI_OE);
    end
    #60;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #20 rst = 1'b0;
    #20;
  endtask

  task automatic test_reset();
    fif.FSCK = 1'b0; fif.FCEN = 1'b1; fif.FDO = 4'h0; fif.FDOEN = 1'b0;
    rst = 1'b1;
    #40;
    total++; if (fif.FDI_OE !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", fif.FDI_OE); end
    total++; if (fif.FDI !== 4'h0) begin bad++; $display("FAIL reset_fdi: got %h want 0", fif.FDI); end
    total++; if (mem_re !== 1'b0) begin bad++; $display("FAIL reset_re: got %b want 0", mem_re); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", proto_err); end
    rst = 1'b0;
    #40;
  endtask

  task automatic test_read_aligned();
    qspi_txn(1'b1, 8'hEB, 24'h000004, 8'h00, 8, 1'b1, 1'b0);
  endtask

  task automatic test_read_unaligned();
    qspi_txn(1'b1, 8'hEB, 24'h000006, 8'h00, 6, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    re_log.delete();
    qspi_txn(1'b1, 8'hEB, 24'h00FFFF, 8'h00, 4, 1'b1, 1'b0);
    total++;
    if (re_log.size() < 2) begin
      bad++;
      $display("FAIL wrap_re_pulses: got %0d want >=2", re_log.size());
    end else begin
      if (re_log[0] !== 14'h3FFF) begin
        bad++;
        $display("FAIL wrap_first_addr: got %h want 3fff", re_log[0]);
      end
      total++;
      if (re_log[1] !== 14'h0000) begin
        bad++;
        $display("FAIL wrap_second_addr: got %h want 0000", re_log[1]);
      end
    end
  endtask

  task automatic test_bad_opcode();
    int n0;
    n0 = re_count;
    qspi_txn(1'b1, 8'h9F, 24'h000004, 8'h00, 12, 1'b0, 1'b0);
    total++;
    if (re_count != n0) begin
      bad++;
      $display("FAIL ignore_mem_re: got %0d pulses want 0", re_count - n0);
    end
    qspi_txn(1'b1, 8'hEB, 24'h000010, 8'h00, 4, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    qspi_txn(1'b1, 8'hEB, 24'h000004, 8'h00, 3, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_addr();
    logic [7:0] op;
    op = 8'hEB;
    fif.FCEN = 1'b0; fif.FDOEN = 1'b1;
    #50;
    for (int i = 7; i >= 0; i--) sck_cycle({3'b000, op[i]});
    for (int i = 0; i < 3; i++) sck_cycle(4'h0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_in_addr: got %b want 1", busy); end
    rst = 1'b1;
    #10;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (mem_addr !== '0) begin bad++; $display("FAIL midrst_addr: got %h want 0", mem_addr); end
    total++; if (mem_re !== 1'b0) begin bad++; $display("FAIL midrst_re: got %b want 0", mem_re); end
    total++; if (fif.FDI_OE !== 1'b0) begin bad++; $display("FAIL midrst_oe: got %b want 0", fif.FDI_OE); end
    #20 rst = 1'b0;
    fif.FDOEN = 1'b0;
    #20 fif.FCEN = 1'b1;
    #100;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy: got %b want 0", busy); end
    qspi_txn(1'b1, 8'hEB, 24'h000020, 8'h00, 4, 1'b1, 1'b0);
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL err_clean_run: got %b want 0", proto_err); end
  endtask

  task automatic test_proto_err();
    logic [7:0] op;
    op = 8'hEB;
    qspi_txn(1'b1, 8'hEB, 24'h000004, 8'h00, 4, 1'b1, 1'b1);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL err_fdoen: got %b want 1", proto_err); end
    qspi_txn(1'b1, 8'hEB, 24'h000008, 8'h00, 2, 1'b1, 1'b0);
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", proto_err); end
    pulse_reset();
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b want 0", proto_err); end
    fif.FCEN = 1'b0; fif.FDOEN = 1'b1;
    #50;
    for (int i = 7; i >= 5; i--) sck_cycle({3'b000, op[i]});
    fif.FDOEN = 1'b0;
    fif.FCEN = 1'b1;
    #100;
    total++; if (proto_err !== 1'b1) begin bad++; $display("FAIL err_short_cmd: got %b want 1", proto_err); end
    pulse_reset();
  endtask

`ifdef QSPI_FLASH_RESPONDER_XIP_EN
  task automatic test_xip();
    qspi_txn(1'b1, 8'hEB, 24'h000004, 8'hA0, 4, 1'b1, 1'b0);
    qspi_txn(1'b0, 8'h00, 24'h000008, 8'h00, 4, 1'b1, 1'b0);
    qspi_txn(1'b1, 8'hEB, 24'h00000C, 8'h00, 4, 1'b1, 1'b0);
  endtask
`else
  task automatic test_mode_ignored();
    qspi_txn(1'b1, 8'hEB, 24'h000004, 8'hA0, 4, 1'b1, 1'b0);
    qspi_txn(1'b1, 8'hEB, 24'h000008, 8'h00, 4, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < (1 << (AW - 2)); i++)
      mem[i] = {8'(i * 4 + 3) ^ 8'h96, 8'(i * 4 + 2) ^ 8'h69, 8'(i * 4 + 1) ^ 8'hC3, 8'(i * 4) ^ 8'h3C};
    mem[1] = 32'hDDCCBBAA;
    mem_rdata = '0;
    test_reset();
    test_read_aligned();
    test_read_unaligned();
    test_wrap();
    test_bad_opcode();
    test_abort();
    test_reset_mid_addr();
    test_proto_err();
`ifdef QSPI_FLASH_RESPONDER_XIP_EN
    test_xip();
`else
    test_mode_ignored();
`endif
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
